lsu_dmem_master: RTL
====================

Name: lsu_dmem_master

Overview:
- Load/store initiator that sits between the core's memory stage and the data memory (dmem).
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the dmem port: Address, WriteData, MemRW (0 = write, 1 = read) and funct3.
- Aligned accesses go to dmem as a single access. Misaligned halfword/word accesses are split into sequential byte accesses and reassembled here.

Parameters:
- ALLOW_MISALIGNED, 1, when 1 misaligned LH/LHU/LW/SH/SW are split into byte accesses; when 0 they return resp_err without touching dmem.

Ports:
- clk  input  1  clock; dmem writes on negedge, this block updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I load/store funct3.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
- resp_err  output  1  illegal funct3, or misaligned with ALLOW_MISALIGNED=0.
- Address  output  32  to dmem.
- WriteData  output  32  to dmem.
- MemRW  output  1  to dmem; 0 = write, 1 = read.
- funct3  output  3  to dmem.
- ReadData  input  32  from dmem, combinational.

Behaviour:
- Reset, asynchronous and immediate: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, Address=0, WriteData=0, MemRW=1, funct3=3'b010. MemRW=1 in every non-write cycle, so dmem never sees a spurious write.
- All dmem outputs are registered on posedge and held stable for the whole cycle, so they are stable at dmem's negedge write and at the next posedge read sample.
- States are IDLE, ACCESS, SPLIT, DONE.
- IDLE:
  - req_ready=1.
  - On posedge with req_valid=1, latch the request.
  - Legal funct3 for loads: 000, 001, 010, 100, 101. For stores: 000, 001, 010. Anything else goes to DONE with resp_err=1 and no dmem access.
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0. Bytes are never misaligned.
  - Aligned request: go to ACCESS, driving Address=req_addr, funct3=req_funct3, MemRW=~req_we, WriteData=req_wdata.
  - Misaligned and ALLOW_MISALIGNED=1: go to SPLIT with idx=0.
  - Misaligned and ALLOW_MISALIGNED=0: go to DONE with resp_err=1.
- ACCESS (1 cycle):
  - dmem performs the access.
  - At the next posedge, capture ReadData into resp_rdata for loads; dmem already extends the value. Stores give resp_rdata=0.
  - Then go to DONE.
- SPLIT (N cycles; N=2 halfword, N=4 word):
  - Cycle idx drives Address=base+idx (32-bit wrap-around, 0xFFFFFFFF+1 = 0).
  - funct3 is 000 for stores, 100 for loads.
  - WriteData={24'b0, wdata[8*idx+7:8*idx]}.
  - MemRW=~req_we.
  - At each posedge, load byte idx into an assembly register from ReadData[7:0].
  - After idx=N-1, apply extension: LH sign-extends from bit 15, LHU zero-extends, LW takes the value as-is. Then go to DONE.
- DONE (1 cycle):
  - resp_valid=1, req_ready=0, MemRW=1.
  - Next state is IDLE. resp_valid deasserts; resp_rdata/resp_err hold until the next response.
- Latency from the accept edge to resp_valid high:
  - Aligned: 1 cycle.
  - Misaligned halfword: 2 cycles.
  - Misaligned word: 4 cycles.
  - Error: 0 extra (DONE directly).
- Throughput: one request per (latency+1) cycles. req_valid while req_ready=0 is ignored; the requester holds it.
- Reset mid-SPLIT: bytes already written at earlier negedges stay in dmem; the remaining bytes are not written and no response is issued.
- resp_valid never asserts without a prior accepted request.

Test Plan:
- Aligned SW addr=0x100, wdata=0xDEADBEEF, then LW 0x100 -> one write cycle with MemRW=0, funct3=010; LW resp_valid 1 cycle after accept, resp_rdata=0xDEADBEEF, resp_err=0.
- Misaligned SW addr=0x101, wdata=0x11223344 -> 4 byte writes at 0x101..0x104 with WriteData 0x44, 0x33, 0x22, 0x11, funct3=000; then LW 0x101 -> 4 byte reads, resp_rdata=0x11223344 on cycle 4.
- Misaligned LH addr=0x203, bytes 0x203=0x80, 0x204=0xFF -> resp_rdata=0xFFFFFF80 (wait: value 0xFF80 sign-extended = 0xFFFFFF80); LHU same address -> 0x0000FF80.
- Illegal funct3 011 load, and SW with funct3 100 -> resp_valid the cycle after accept, resp_err=1, resp_rdata=0, MemRW stays 1 throughout.
- ALLOW_MISALIGNED=0, LW addr=0x102 -> resp_err=1, no dmem cycle; wrap case (ALLOW_MISALIGNED=1) LH addr=0xFFFFFFFF -> second byte read from Address=0x00000000.
- Assert rst during SPLIT of SW 0x301 after 2 bytes -> outputs reset immediately, MemRW=1, bytes 0x301/0x302 updated, 0x303/0x304 unchanged, no resp_valid.

Source files
------------

// File: rtl/lsu_dmem_master_if.sv
// rtl/lsu_dmem_master_if.sv - request/response and dmem port bundle for lsu_dmem_master
interface lsu_dmem_master_if;
  // Core-side request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Core-side response
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // dmem port (MemRW: 0 = write, 1 = read)
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRW;
  logic [2:0]  funct3;
  logic [31:0] ReadData;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ReadData,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output Address, WriteData, MemRW, funct3
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ReadData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  Address, WriteData, MemRW, funct3
  );
endinterface

// File: rtl/lsu_dmem_master.sv
// rtl/lsu_dmem_master.sv - load/store initiator that splits misaligned accesses into byte cycles
module lsu_dmem_master #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic               clk,
  input logic               rst,
  lsu_dmem_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt, idx_inc, last_idx;
  logic        lat_we, lat_we_nxt;
  logic [2:0]  lat_f3, lat_f3_nxt;
  logic [31:0] lat_addr, lat_addr_nxt;
  logic [31:0] lat_wdata, lat_wdata_nxt;
  logic [31:0] asm_q, asm_nxt, asm_full, asm_ext;
  logic        resp_valid_q, resp_valid_nxt;
  logic        resp_err_q, resp_err_nxt;
  logic [31:0] resp_rdata_q, resp_rdata_nxt;
  logic [31:0] address_q, address_nxt;
  logic [31:0] write_data_q, write_data_nxt;
  logic        mem_rw_q, mem_rw_nxt;
  logic [2:0]  dmem_f3_q, dmem_f3_nxt;
  logic        req_legal, req_misaligned;

  // Classify the incoming request: legal funct3 for its direction and natural alignment.
  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    if (bus.req_we) begin
      req_legal = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      req_legal = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    case (bus.req_funct3[1:0])
      2'b01:   req_misaligned = bus.req_addr[0];
      2'b10:   req_misaligned = (bus.req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  // Merge the byte read this cycle into the assembly value and apply the load extension.
  always_comb begin
    asm_full = asm_q;
    case (idx)
      2'd0:    asm_full[7:0]   = bus.ReadData[7:0];
      2'd1:    asm_full[15:8]  = bus.ReadData[7:0];
      2'd2:    asm_full[23:16] = bus.ReadData[7:0];
      default: asm_full[31:24] = bus.ReadData[7:0];
    endcase
    case (lat_f3)
      3'b001:  asm_ext = {{16{asm_full[15]}}, asm_full[15:0]};
      3'b101:  asm_ext = {16'h0000, asm_full[15:0]};
      default: asm_ext = asm_full;
    endcase
    last_idx = (lat_f3[1:0] == 2'b01) ? 2'd1 : 2'd3;
    idx_inc  = idx + 2'd1;
  end

  // Next state and next registered outputs; MemRW falls back to read unless a write is due.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    lat_we_nxt     = lat_we;
    lat_f3_nxt     = lat_f3;
    lat_addr_nxt   = lat_addr;
    lat_wdata_nxt  = lat_wdata;
    asm_nxt        = asm_q;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = resp_err_q;
    resp_rdata_nxt = resp_rdata_q;
    address_nxt    = address_q;
    write_data_nxt = write_data_q;
    mem_rw_nxt     = 1'b1;
    dmem_f3_nxt    = dmem_f3_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          lat_we_nxt    = bus.req_we;
          lat_f3_nxt    = bus.req_funct3;
          lat_addr_nxt  = bus.req_addr;
          lat_wdata_nxt = bus.req_wdata;
          idx_nxt       = 2'd0;
          asm_nxt       = 32'h0;
          if (!req_legal || (req_misaligned && !ALLOW_MISALIGNED)) begin
            state_nxt      = DONE;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
            resp_rdata_nxt = 32'h0;
          end else if (req_misaligned) begin
            state_nxt      = SPLIT;
            address_nxt    = bus.req_addr;
            dmem_f3_nxt    = bus.req_we ? 3'b000 : 3'b100;
            write_data_nxt = {24'h0, bus.req_wdata[7:0]};
            mem_rw_nxt     = ~bus.req_we;
          end else begin
            state_nxt      = ACCESS;
            address_nxt    = bus.req_addr;
            dmem_f3_nxt    = bus.req_funct3;
            write_data_nxt = bus.req_wdata;
            mem_rw_nxt     = ~bus.req_we;
          end
        end
      end
      ACCESS: begin
        state_nxt      = DONE;
        resp_valid_nxt = 1'b1;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = lat_we ? 32'h0 : bus.ReadData;
      end
      SPLIT: begin
        asm_nxt = asm_full;
        if (idx == last_idx) begin
          state_nxt      = DONE;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b0;
          resp_rdata_nxt = lat_we ? 32'h0 : asm_ext;
        end else begin
          idx_nxt        = idx_inc;
          address_nxt    = lat_addr + {30'h0, idx_inc};
          write_data_nxt = {24'h0, lat_wdata[{idx_inc, 3'b000} +: 8]};
          mem_rw_nxt     = ~lat_we;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset parks dmem in a harmless read of address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 2'd0;
      lat_we       <= 1'b0;
      lat_f3       <= 3'b000;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      asm_q        <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      address_q    <= 32'h0;
      write_data_q <= 32'h0;
      mem_rw_q     <= 1'b1;
      dmem_f3_q    <= 3'b010;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      lat_we       <= lat_we_nxt;
      lat_f3       <= lat_f3_nxt;
      lat_addr     <= lat_addr_nxt;
      lat_wdata    <= lat_wdata_nxt;
      asm_q        <= asm_nxt;
      resp_valid_q <= resp_valid_nxt;
      resp_err_q   <= resp_err_nxt;
      resp_rdata_q <= resp_rdata_nxt;
      address_q    <= address_nxt;
      write_data_q <= write_data_nxt;
      mem_rw_q     <= mem_rw_nxt;
      dmem_f3_q    <= dmem_f3_nxt;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.Address    = address_q;
  assign bus.WriteData  = write_data_q;
  assign bus.MemRW      = mem_rw_q;
  assign bus.funct3     = dmem_f3_q;

endmodule
